// File: rtl/cr_channel_allocator.sv
// +----------------------------------------------------------------------------+
// | cr_channel_allocator: per-channel primary-user sensing FSMs with a        |
// | single round-robin grant per cycle to unlicensed users.   Rev 1.0         |
// +----------------------------------------------------------------------------+
`default_nettype none

module cr_channel_allocator #(
  parameter int DATA_W    = 32,
  parameter int N_CH      = 3,
  parameter int N_SU      = 6,
  parameter int IDLE_HOLD = 4
) (
  input  logic                                             clk,
  input  logic                                             rst,
  input  logic [N_CH-1:0]                                  pu_active,
  input  logic [N_CH*DATA_W-1:0]                           pu_data,
  input  logic [N_SU-1:0]                                  su_req,
  input  logic [N_SU*DATA_W-1:0]                           su_data,
  output logic [N_CH*DATA_W-1:0]                           ch_data,
  output logic [N_CH*((N_SU > 1) ? $clog2(N_SU) : 1)-1:0]  ch_owner,
  output logic [N_CH-1:0]                                  ch_assigned,
  output logic [N_SU-1:0]                                  su_grant,
  output logic [N_SU-1:0]                                  su_evict
);

  localparam int         SU_IDW    = (N_SU > 1) ? $clog2(N_SU) : 1;
  localparam logic [7:0] HOLD_LAST = 8'(IDLE_HOLD - 1);

  typedef enum logic [1:0] {
    ST_BUSY_PU  = 2'd0,
    ST_SENSE    = 2'd1,
    ST_FREE     = 2'd2,
    ST_ASSIGNED = 2'd3
  } ch_state_t;

  ch_state_t             state_q [N_CH];
  ch_state_t             state_d [N_CH];
  logic [7:0]            cnt_q   [N_CH];
  logic [7:0]            cnt_d   [N_CH];
  logic [SU_IDW-1:0]     owner_q [N_CH];
  logic [SU_IDW-1:0]     owner_d [N_CH];
  logic [SU_IDW-1:0]     rr_q, rr_d;
  logic [N_SU-1:0]       su_grant_q, su_grant_d;
  logic [N_SU-1:0]       su_evict_q, su_evict_d;
  logic [N_CH*DATA_W-1:0] ch_data_q, ch_data_d;

  logic [N_SU-1:0]       pending;
  logic [N_CH-1:0]       free_vec;
  logic [N_CH-1:0]       gnt_oh;
  logic [SU_IDW-1:0]     gnt_su;
  logic [SU_IDW-1:0]     cand_idx;
  logic                  su_found;
  logic                  gnt_fire;
  int                    cand;

  // Channel pick: lowest FREE channel whose licensed user stays away this edge.
  always_comb begin
    pending  = su_req & ~su_grant_q;
    free_vec = '0;
    for (int i = 0; i < N_CH; i++) begin
      free_vec[i] = (state_q[i] == ST_FREE) && !pu_active[i];
    end
    gnt_oh = free_vec & (~free_vec + N_CH'(1));

    su_found = 1'b0;
    gnt_su   = '0;
    cand     = 0;
    cand_idx = '0;
    for (int k = 0; k < N_SU; k++) begin
      cand = int'(rr_q) + k;
      if (cand >= N_SU) cand = cand - N_SU;
      cand_idx = SU_IDW'(cand);
      if (!su_found && pending[cand_idx]) begin
        su_found = 1'b1;
        gnt_su   = cand_idx;
      end
    end
    gnt_fire = su_found && (|gnt_oh);
  end

  always_comb begin
    su_grant_d = su_grant_q;
    su_evict_d = '0;
    rr_d       = rr_q;
    ch_data_d  = '0;
    for (int i = 0; i < N_CH; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      owner_d[i] = owner_q[i];

      // A returning licensed user wins over every other event on the channel.
      if (pu_active[i]) begin
        state_d[i] = ST_BUSY_PU;
        if (state_q[i] == ST_ASSIGNED) begin
          su_evict_d[owner_q[i]] = 1'b1;
          su_grant_d[owner_q[i]] = 1'b0;
        end
      end else begin
        case (state_q[i])
          ST_BUSY_PU: begin
            state_d[i] = ST_SENSE;
            cnt_d[i]   = '0;
          end
          ST_SENSE: begin
            if (cnt_q[i] == HOLD_LAST) state_d[i] = ST_FREE;
            else                       cnt_d[i]   = cnt_q[i] + 8'd1;
          end
          ST_FREE: begin
            if (gnt_fire && gnt_oh[i]) begin
              state_d[i]         = ST_ASSIGNED;
              owner_d[i]         = gnt_su;
              su_grant_d[gnt_su] = 1'b1;
            end
          end
          ST_ASSIGNED: begin
            if (!su_req[owner_q[i]]) begin
              state_d[i]             = ST_FREE;
              su_grant_d[owner_q[i]] = 1'b0;
            end
          end
          default: state_d[i] = ST_SENSE;
        endcase
      end

      if (pu_active[i])
        ch_data_d[i*DATA_W +: DATA_W] = pu_data[i*DATA_W +: DATA_W];
      else if (state_d[i] == ST_ASSIGNED)
        ch_data_d[i*DATA_W +: DATA_W] = su_data[owner_d[i]*DATA_W +: DATA_W];
    end

    if (gnt_fire) begin
      if (gnt_su == SU_IDW'(N_SU - 1)) rr_d = '0;
      else                             rr_d = gnt_su + SU_IDW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_CH; i++) begin
        state_q[i] <= ST_SENSE;
        cnt_q[i]   <= '0;
        owner_q[i] <= '0;
      end
      rr_q       <= '0;
      su_grant_q <= '0;
      su_evict_q <= '0;
      ch_data_q  <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
        owner_q[i] <= owner_d[i];
      end
      rr_q       <= rr_d;
      su_grant_q <= su_grant_d;
      su_evict_q <= su_evict_d;
      ch_data_q  <= ch_data_d;
    end
  end

  generate
    for (genvar i = 0; i < N_CH; i++) begin : g_ch_out
      assign ch_assigned[i]               = (state_q[i] == ST_ASSIGNED);
      assign ch_owner[i*SU_IDW +: SU_IDW] = owner_q[i];
    end
  endgenerate

  assign ch_data  = ch_data_q;
  assign su_grant = su_grant_q;
  assign su_evict = su_evict_q;

endmodule

`default_nettype wire
